// File: rtl/brick_wall_tracker_if.sv
// Hit/reload inputs and empty-flag/brick-count outputs of the brick wall tracker.
// master drives hits and reloads; slave is the tracker.
interface brick_wall_tracker_if;
  logic       BRICK_HIT;
  logic [2:0] BRICK_ROW;
  logic       PLAYER;
  logic       FPD1;
  logic       FPD2;
  logic       START_GAME1_N;
  logic       D1, G1, K1;
  logic       D2, G2, K2;
  logic [7:0] BRICKS_LEFT1;
  logic [7:0] BRICKS_LEFT2;

  modport master (
    output BRICK_HIT, BRICK_ROW, PLAYER, FPD1, FPD2, START_GAME1_N,
    input  D1, G1, K1, D2, G2, K2, BRICKS_LEFT1, BRICKS_LEFT2
  );

  modport slave (
    input  BRICK_HIT, BRICK_ROW, PLAYER, FPD1, FPD2, START_GAME1_N,
    output D1, G1, K1, D2, G2, K2, BRICKS_LEFT1, BRICKS_LEFT2
  );
endinterface

// File: rtl/brick_wall_tracker.sv
// Per-player brick counters for wall sections D/G/K with registered empty flags.
// Optional hit lockout timer is enabled by defining BRICK_HIT_HOLDOFF_EN.
module brick_wall_tracker #(
  parameter int BRICKS_PER_ROW = 28,
  parameter int D_ROWS         = 2,
  parameter int G_ROWS         = 3,
  parameter int K_ROWS         = 3,
  parameter int HOLDOFF        = 64
) (
  input  logic                  CLK_DRV,
  input  logic                  RESET,
  brick_wall_tracker_if.slave   bus
);

  localparam int D_SIZE   = D_ROWS * BRICKS_PER_ROW;
  localparam int G_SIZE   = G_ROWS * BRICKS_PER_ROW;
  localparam int K_SIZE   = K_ROWS * BRICKS_PER_ROW;
  localparam int DG_MAX   = (D_SIZE > G_SIZE) ? D_SIZE : G_SIZE;
  localparam int MAX_SIZE = (DG_MAX > K_SIZE) ? DG_MAX : K_SIZE;
  localparam int CNT_W    = $clog2(MAX_SIZE + 1);
  localparam int TOTAL    = D_SIZE + G_SIZE + K_SIZE;

  if (TOTAL > 255) begin : g_bad_total
    $error("brick_wall_tracker: total bricks %0d do not fit 8 bits", TOTAL);
  end
  if (D_ROWS + G_ROWS + K_ROWS > 8) begin : g_bad_rows
    $error("brick_wall_tracker: more than 8 rows mapped");
  end
  if (HOLDOFF < 1) begin : g_bad_holdoff
    $error("brick_wall_tracker: HOLDOFF must be at least 1");
  end

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t full_size(input int s);
    case (s)
      0:       return cnt_t'(D_SIZE);
      1:       return cnt_t'(G_SIZE);
      default: return cnt_t'(K_SIZE);
    endcase
  endfunction

  cnt_t       cnt     [2][3];
  cnt_t       cnt_nxt [2][3];
  logic       empty   [2][3];
  logic [7:0] left_q  [2];
  logic [7:0] left_nxt[2];
  logic [1:0] fpd_d;
  logic [1:0] reload;
  logic [1:0] hit_sec;
  logic       row_valid;
  logic       hold_open;
  logic       hit_take;

  // Rows beyond the last mapped section belong to no wall and are ignored.
  always_comb begin
    row_valid = 1'b1;
    hit_sec   = 2'd0;
    if (int'(bus.BRICK_ROW) < D_ROWS)
      hit_sec = 2'd0;
    else if (int'(bus.BRICK_ROW) < D_ROWS + G_ROWS)
      hit_sec = 2'd1;
    else if (int'(bus.BRICK_ROW) < D_ROWS + G_ROWS + K_ROWS)
      hit_sec = 2'd2;
    else
      row_valid = 1'b0;
  end

  assign reload[0] = ~bus.START_GAME1_N | (bus.FPD1 & ~fpd_d[0]);
  assign reload[1] = ~bus.START_GAME1_N | (bus.FPD2 & ~fpd_d[1]);
  assign hit_take  = bus.BRICK_HIT & row_valid & hold_open;

`ifdef BRICK_HIT_HOLDOFF_EN
  localparam int TMR_W = $clog2(HOLDOFF + 1);
  logic [TMR_W-1:0] holdoff_tmr;

  assign hold_open = (holdoff_tmr == '0);

  // Dropped hits never reach hit_take, so they cannot restart the lockout.
  always_ff @(posedge CLK_DRV) begin
    if (RESET || (|reload))
      holdoff_tmr <= '0;
    else if (hit_take)
      holdoff_tmr <= TMR_W'(HOLDOFF);
    else if (!hold_open)
      holdoff_tmr <= holdoff_tmr - 1'b1;
  end
`else
  assign hold_open = 1'b1;
`endif

  // Reload wins over a hit on the same wall; an empty section swallows hits.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 3; s++) begin
        cnt_nxt[p][s] = cnt[p][s];
        if (reload[p])
          cnt_nxt[p][s] = full_size(s);
        else if (hit_take && (int'(bus.PLAYER) == p) && (int'(hit_sec) == s) &&
                 (cnt[p][s] != '0))
          cnt_nxt[p][s] = cnt[p][s] - 1'b1;
      end
      left_nxt[p] = 8'(cnt_nxt[p][0]) + 8'(cnt_nxt[p][1]) + 8'(cnt_nxt[p][2]);
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      fpd_d <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        left_q[p] <= 8'(TOTAL);
        for (int s = 0; s < 3; s++) begin
          cnt[p][s]   <= full_size(s);
          empty[p][s] <= 1'b0;
        end
      end
    end else begin
      fpd_d <= {bus.FPD2, bus.FPD1};
      for (int p = 0; p < 2; p++) begin
        left_q[p] <= left_nxt[p];
        for (int s = 0; s < 3; s++) begin
          cnt[p][s]   <= cnt_nxt[p][s];
          empty[p][s] <= (cnt_nxt[p][s] == '0);
        end
      end
    end
  end

  assign bus.D1           = empty[0][0];
  assign bus.G1           = empty[0][1];
  assign bus.K1           = empty[0][2];
  assign bus.D2           = empty[1][0];
  assign bus.G2           = empty[1][1];
  assign bus.K2           = empty[1][2];
  assign bus.BRICKS_LEFT1 = left_q[0];
  assign bus.BRICKS_LEFT2 = left_q[1];

endmodule

// File: tb/tb_brick_wall_tracker.sv
// Directed bench for brick_wall_tracker (default build and BRICK_HIT_HOLDOFF_EN).
// A second instance with K_ROWS=2 exercises the unmapped-row case.
module tb_brick_wall_tracker;

  localparam int HOLDOFF = 64;
  localparam int GAP     = HOLDOFF + 1;

  logic CLK_DRV = 1'b0;
  logic RESET;
  int   n_cmp  = 0;
  int   n_fail = 0;

  brick_wall_tracker_if bus ();
  brick_wall_tracker_if bus7 ();

  brick_wall_tracker #(.HOLDOFF(HOLDOFF)) dut (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .bus     (bus)
  );

  brick_wall_tracker #(.K_ROWS(2), .HOLDOFF(HOLDOFF)) dut7 (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .bus     (bus7)
  );

  assign bus7.BRICK_HIT     = bus.BRICK_HIT;
  assign bus7.BRICK_ROW     = bus.BRICK_ROW;
  assign bus7.PLAYER        = bus.PLAYER;
  assign bus7.FPD1          = bus.FPD1;
  assign bus7.FPD2          = bus.FPD2;
  assign bus7.START_GAME1_N = bus.START_GAME1_N;

  always #5 CLK_DRV = ~CLK_DRV;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [5:0] exp);
    check_output(tag, {2'b00, bus.D1, bus.G1, bus.K1, bus.D2, bus.G2, bus.K2}, {2'b00, exp});
  endtask

  // Presents one hit for a single cycle starting at the current negedge.
  task automatic apply_stimulus(input logic player, input logic [2:0] row);
    bus.BRICK_HIT = 1'b1;
    bus.PLAYER    = player;
    bus.BRICK_ROW = row;
    @(negedge CLK_DRV);
    bus.BRICK_HIT = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_DRV);
  endtask

  initial begin
    RESET             = 1'b1;
    bus.BRICK_HIT     = 1'b0;
    bus.BRICK_ROW     = 3'd0;
    bus.PLAYER        = 1'b0;
    bus.FPD1          = 1'b0;
    bus.FPD2          = 1'b0;
    bus.START_GAME1_N = 1'b1;
    idle(2);
    RESET = 1'b0;

    check_flags("reset_flags", 6'b000000);
    check_output("reset_left1", bus.BRICKS_LEFT1, 8'd224);
    check_output("reset_left2", bus.BRICKS_LEFT2, 8'd224);
    check_output("reset_left1_k2", bus7.BRICKS_LEFT1, 8'd196);

    for (int i = 1; i <= 57; i++) begin
      apply_stimulus(1'b0, 3'd1);
      if (i == 55) begin
        check_flags("d1_before_empty", 6'b000000);
        check_output("left1_55", bus.BRICKS_LEFT1, 8'd169);
      end else if (i == 56) begin
        check_flags("d1_empty", 6'b100000);
        check_output("left1_56", bus.BRICKS_LEFT1, 8'd168);
      end else if (i == 57) begin
        check_flags("d1_saturated", 6'b100000);
        check_output("left1_57", bus.BRICKS_LEFT1, 8'd168);
      end
      idle(GAP);
    end

    for (int i = 0; i < 84; i++) begin
      apply_stimulus(1'b0, 3'd3);
      idle(GAP);
    end
    check_flags("g1_empty", 6'b110000);
    for (int i = 0; i < 84; i++) begin
      apply_stimulus(1'b0, 3'd6);
      idle(GAP);
    end
    check_flags("p1_all_empty", 6'b111000);
    check_output("left1_zero", bus.BRICKS_LEFT1, 8'd0);
    check_output("left2_untouched", bus.BRICKS_LEFT2, 8'd224);

    bus.FPD1 = 1'b1;
    idle(1);
    check_flags("fpd1_reload_flags", 6'b000000);
    check_output("fpd1_reload_left1", bus.BRICKS_LEFT1, 8'd224);
    idle(2);
    apply_stimulus(1'b0, 3'd0);
    check_output("fpd1_held_hit", bus.BRICKS_LEFT1, 8'd223);
    bus.FPD1 = 1'b0;
    idle(GAP);

    bus.FPD1 = 1'b1;
    apply_stimulus(1'b0, 3'd4);
    check_output("reload_eats_hit", bus.BRICKS_LEFT1, 8'd224);
    bus.FPD1 = 1'b0;
    idle(GAP);
    bus.FPD1 = 1'b1;
    apply_stimulus(1'b1, 3'd4);
    check_output("reload_other_p1", bus.BRICKS_LEFT1, 8'd224);
    check_output("reload_other_p2", bus.BRICKS_LEFT2, 8'd223);
    check_flags("reload_other_flags", 6'b000000);
    bus.FPD1 = 1'b0;
    idle(GAP);

    bus.START_GAME1_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'(i % 2), 3'd2);
      check_flags("start_flags", 6'b000000);
      check_output("start_left1", bus.BRICKS_LEFT1, 8'd224);
      check_output("start_left2", bus.BRICKS_LEFT2, 8'd224);
    end
    bus.START_GAME1_N = 1'b1;
    check_output("start_left1_k2", bus7.BRICKS_LEFT1, 8'd196);
    check_output("start_left2_k2", bus7.BRICKS_LEFT2, 8'd196);
    idle(GAP);

    apply_stimulus(1'b0, 3'd7);
    check_output("row7_valid", bus.BRICKS_LEFT1, 8'd223);
    check_output("row7_ignored", bus7.BRICKS_LEFT1, 8'd196);
    idle(GAP);
    apply_stimulus(1'b0, 3'd6);
    check_output("row6_main", bus.BRICKS_LEFT1, 8'd222);
    check_output("row6_k2", bus7.BRICKS_LEFT1, 8'd195);
    idle(GAP);

    apply_stimulus(1'b1, 3'd0);
    check_output("hold_first", bus.BRICKS_LEFT2, 8'd223);
    idle(9);
    apply_stimulus(1'b1, 3'd0);
`ifdef BRICK_HIT_HOLDOFF_EN
    check_output("hold_second", bus.BRICKS_LEFT2, 8'd223);
`else
    check_output("hold_second", bus.BRICKS_LEFT2, 8'd222);
`endif
    idle(54);
    apply_stimulus(1'b1, 3'd0);
`ifdef BRICK_HIT_HOLDOFF_EN
    check_output("hold_expired", bus.BRICKS_LEFT2, 8'd222);
`else
    check_output("hold_expired", bus.BRICKS_LEFT2, 8'd221);
`endif
    check_flags("final_flags", 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
